// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the multiply/divide unit.
package cpu_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned REG_ADDR_W = 2;
  localparam int unsigned CNT_W      = 5;

  // Quotient returned when dividing by zero.
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    OpMulLo = 2'b00,
    OpMulHi = 2'b01,
    OpDivU  = 2'b10,
    OpRemU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StDone = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the control unit / register file and the muldiv unit.
interface muldiv_unit_if;
  import cpu_pkg::*;

  logic                  start;
  op_e                   op;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic [REG_ADDR_W-1:0] dest_in;
  logic                  busy;
  logic                  done;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd;
  logic [WIDTH-1:0]      write_data;
  logic                  div_by_zero;

  // Control unit / register-file side.
  modport master (
    output start, op, op_a, op_b, dest_in,
    input  busy, done, reg_write, rd, write_data, div_by_zero
  );

  // Execution unit side.
  modport slave (
    input  start, op, op_a, op_b, dest_in,
    output busy, done, reg_write, rd, write_data, div_by_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Multiply: acc = {partial product high, remaining multiplier bits}.
// Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}.
module muldiv_step
  import cpu_pkg::*;
(
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;
  logic             w_unused_msb;

  // Top bits of the remainder paths are provably zero once selected; sink them.
  assign w_unused_msb = w_diff[WIDTH] ^ w_shifted[WIDTH];

  // Compute both candidate steps and pick by mode.
  always_comb begin
    w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    // 17-bit partial remainder: old remainder with next dividend bit shifted in.
    w_shifted = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff    = {1'b0, w_shifted} - {2'b00, i_operand};
    w_fits    = ~w_diff[WIDTH+1];
    if (i_div) begin
      if (w_fits) begin
        o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_shifted[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide unit, one bit per clock.
// Results are written back through a one-cycle RegWrite pulse in the DONE state.
module muldiv_unit
  import cpu_pkg::*;
(
  input logic          i_clock,
  input logic          i_reset_n,
  muldiv_unit_if.slave bus
);

  state_e                r_state;
  state_e                w_state_next;
  logic [2*WIDTH-1:0]    r_acc;
  logic [2*WIDTH-1:0]    w_step;
  logic [WIDTH-1:0]      r_opb;
  logic [WIDTH-1:0]      r_write_data;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sel_hi;
  logic                  r_div_by_zero;
  logic                  w_accept;
  logic                  w_div0;
  logic                  w_last;
  logic                  w_iterating;

  assign w_accept    = (r_state == StIdle) && bus.start;
  assign w_div0      = bus.op[1] && (bus.op_b == '0);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_iterating = (r_state == StMul) || (r_state == StDiv);

  muldiv_step u_step (
    .i_acc     (r_acc),
    .i_operand (r_opb),
    .i_div     (r_state == StDiv),
    .o_acc     (w_step)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; Start is only looked at in IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          if (!bus.op[1]) begin
            w_state_next = StMul;
          end else if (w_div0) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StDiv;
          end
        end
      end
      StMul, StDiv: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Operand capture, iteration and result latch.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc         <= '0;
      r_opb         <= '0;
      r_sel_hi      <= 1'b0;
      r_rd          <= '0;
      r_cnt         <= '0;
      r_div_by_zero <= 1'b0;
      r_write_data  <= '0;
    end else if (w_accept) begin
      // Multiply and divide both start from {0, OpA}.
      r_acc         <= {{WIDTH{1'b0}}, bus.op_a};
      r_opb         <= bus.op_b;
      r_sel_hi      <= bus.op[0];
      r_rd          <= bus.dest_in;
      r_cnt         <= '0;
      r_div_by_zero <= w_div0;
      if (w_div0) begin
        r_write_data <= bus.op[0] ? bus.op_a : DIV0_QUOTIENT;
      end
    end else if (w_iterating) begin
      r_acc <= w_step;
      r_cnt <= r_cnt + CNT_W'(1);
      // High half is MULHI / remainder, low half is MULLO / quotient.
      if (w_last) begin
        r_write_data <= r_sel_hi ? w_step[2*WIDTH-1:WIDTH] : w_step[WIDTH-1:0];
      end
    end
  end

  assign bus.busy        = (r_state != StIdle);
  assign bus.done        = (r_state == StDone);
  assign bus.reg_write   = (r_state == StDone);
  assign bus.rd          = r_rd;
  assign bus.write_data  = r_write_data;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import cpu_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  muldiv_unit_if bus_if ();

  muldiv_unit u_dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE and check latency, result and the one-cycle pulse.
  task automatic run_op(input string tag, input op_e op, input logic [15:0] a,
                        input logic [15:0] b, input logic [1:0] dest,
                        input logic [15:0] exp_data, input logic exp_dbz, input int exp_lat);
    int lat;
    bus_if.start   = 1'b1;
    bus_if.op      = op;
    bus_if.op_a    = a;
    bus_if.op_b    = b;
    bus_if.dest_in = dest;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.op_a  = 16'h5A5A;
    bus_if.op_b  = 16'h0003;
    check({tag, "/busy"}, 32'(bus_if.busy), 32'd1);
    lat = 0;
    while (!bus_if.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/data"}, 32'(bus_if.write_data), 32'(exp_data));
    check({tag, "/rd"}, 32'(bus_if.rd), 32'(dest));
    check({tag, "/regwrite"}, 32'(bus_if.reg_write), 32'd1);
    check({tag, "/dbz"}, 32'(bus_if.div_by_zero), 32'(exp_dbz));
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 32'({bus_if.done, bus_if.reg_write, bus_if.busy}), 32'd0);
    check({tag, "/data_hold"}, 32'(bus_if.write_data), 32'(exp_data));
    check({tag, "/dbz_hold"}, 32'(bus_if.div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    int          ndone;
    int          lat;
    logic [15:0] first_data;

    bus_if.start   = 1'b0;
    bus_if.op      = OpMulLo;
    bus_if.op_a    = '0;
    bus_if.op_b    = '0;
    bus_if.dest_in = '0;
    #1;
    check("reset/outs", 32'({bus_if.busy, bus_if.done, bus_if.reg_write, bus_if.div_by_zero}),
          32'd0);
    check("reset/data", 32'(bus_if.write_data), 32'd0);
    check("reset/rd", 32'(bus_if.rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mullo_300x200", OpMulLo, 16'd300,  16'd200,  2'd3, 16'hEA60, 1'b0, 16);
    run_op("mulhi_ffff",    OpMulHi, 16'hFFFF, 16'hFFFF, 2'd1, 16'hFFFE, 1'b0, 16);
    run_op("mullo_ffff",    OpMulLo, 16'hFFFF, 16'hFFFF, 2'd2, 16'h0001, 1'b0, 16);
    run_op("divu_100_7",    OpDivU,  16'd100,  16'd7,    2'd1, 16'd14,   1'b0, 16);
    run_op("remu_100_7",    OpRemU,  16'd100,  16'd7,    2'd2, 16'd2,    1'b0, 16);
    run_op("divu_5_9",      OpDivU,  16'd5,    16'd9,    2'd3, 16'd0,    1'b0, 16);
    run_op("remu_5_9_r0",   OpRemU,  16'd5,    16'd9,    2'd0, 16'd5,    1'b0, 16);
    run_op("divu_by0",      OpDivU,  16'h1234, 16'h0000, 2'd1, 16'hFFFF, 1'b1, 0);
    run_op("remu_by0",      OpRemU,  16'h1234, 16'h0000, 2'd2, 16'h1234, 1'b1, 0);
    // DivByZero must clear on the next accepted Start.
    run_op("divu_big",      OpDivU,  16'hFFFF, 16'hFFFF, 2'd3, 16'd1,    1'b0, 16);

    // Start held for 20 edges with operands changing after the sampling edge.
    ndone          = 0;
    first_data     = '0;
    bus_if.start   = 1'b1;
    bus_if.op      = OpMulLo;
    bus_if.op_a    = 16'd300;
    bus_if.op_b    = 16'd200;
    bus_if.dest_in = 2'd1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus_if.done) begin
        ndone++;
        if (ndone == 1) first_data = bus_if.write_data;
      end
      if (c == 17) check("held/idle_gap", 32'(bus_if.busy), 32'd0);
      if (c == 18) check("held/second_accept", 32'(bus_if.busy), 32'd1);
      bus_if.op_a = 16'(c + 1);
      bus_if.op_b = 16'(c + 7);
    end
    bus_if.start = 1'b0;
    check("held/done_count", 32'(ndone), 32'd1);
    check("held/first_data", 32'(first_data), 32'hEA60);
    lat = 0;
    while (!bus_if.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    // Second op sampled operands 18 and 24 at its accepting edge.
    check("held/second_data", 32'(bus_if.write_data), 32'd432);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a multiply.
    bus_if.start   = 1'b1;
    bus_if.op      = OpMulLo;
    bus_if.op_a    = 16'd300;
    bus_if.op_b    = 16'd200;
    bus_if.dest_in = 2'd2;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst/outs", 32'({bus_if.busy, bus_if.done, bus_if.reg_write}), 32'd0);
    check("rst/data", 32'(bus_if.write_data), 32'd0);
    #3;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus_if.done || bus_if.reg_write) ndone++;
    end
    check("rst/no_done", 32'(ndone), 32'd0);
    check("rst/idle", 32'(bus_if.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
